// File: rtl/alsu_cmd_driver_if.sv
// Bundle of request, response, ALSU pin and monitor signals for alsu_cmd_driver.
// "slave" is the driver's view; "master" is the controller/ALSU side.
interface alsu_cmd_driver_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_a;
  logic [2:0]  req_b;
  logic [2:0]  req_opcode;
  logic        req_cin;
  logic        req_serial_in;
  logic        req_direction;
  logic        req_red_a;
  logic        req_red_b;
  logic        req_bypass_a;
  logic        req_bypass_b;

  logic [2:0]  alsu_a;
  logic [2:0]  alsu_b;
  logic [2:0]  alsu_opcode;
  logic        alsu_cin;
  logic        alsu_serial_in;
  logic        alsu_direction;
  logic        alsu_red_a;
  logic        alsu_red_b;
  logic        alsu_bypass_a;
  logic        alsu_bypass_b;
  logic [5:0]  alsu_out;
  logic [15:0] alsu_leds;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [5:0]  rsp_out;
  logic        rsp_err;
  logic        mon_fault;
  logic [15:0] op_count;
  logic [15:0] err_count;

  modport slave (
    input  req_valid, req_a, req_b, req_opcode, req_cin, req_serial_in,
           req_direction, req_red_a, req_red_b, req_bypass_a, req_bypass_b,
           alsu_out, alsu_leds, rsp_ready,
    output req_ready, alsu_a, alsu_b, alsu_opcode, alsu_cin, alsu_serial_in,
           alsu_direction, alsu_red_a, alsu_red_b, alsu_bypass_a, alsu_bypass_b,
           rsp_valid, rsp_out, rsp_err, mon_fault, op_count, err_count
  );

  modport master (
    output req_valid, req_a, req_b, req_opcode, req_cin, req_serial_in,
           req_direction, req_red_a, req_red_b, req_bypass_a, req_bypass_b,
           alsu_out, alsu_leds, rsp_ready,
    input  req_ready, alsu_a, alsu_b, alsu_opcode, alsu_cin, alsu_serial_in,
           alsu_direction, alsu_red_a, alsu_red_b, alsu_bypass_a, alsu_bypass_b,
           rsp_valid, rsp_out, rsp_err, mon_fault, op_count, err_count
  );
endinterface

// File: rtl/alsu_cmd_driver.sv
// Single-outstanding command driver for an ALSU: drives one command for one cycle,
// waits out the ALSU latency, captures out/leds and returns them with an error flag.
module alsu_cmd_driver #(
  parameter int LAT = 2
) (
  input logic              clk,
  input logic              rst,
  alsu_cmd_driver_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRIVE = 3'd1,
    WAIT  = 3'd2,
    CAPT  = 3'd3,
    RESP  = 3'd4
  } state_t;

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] opcode;
    logic       cin;
    logic       serial_in;
    logic       direction;
    logic       red_a;
    logic       red_b;
    logic       bypass_a;
    logic       bypass_b;
  } cmd_t;

  // Bypass of A=0 is a valid ALSU op, so it parks out=0 and leds=0 between commands.
  localparam cmd_t IDLE_CMD = '{a: 3'd0, b: 3'd0, opcode: 3'b000, cin: 1'b0,
                                serial_in: 1'b0, direction: 1'b0, red_a: 1'b0,
                                red_b: 1'b0, bypass_a: 1'b1, bypass_b: 1'b0};
  localparam logic [3:0] WAIT_LOAD = 4'(LAT - 1);

  generate
    if (LAT < 2 || LAT > 15) begin : g_lat_range_check
      $error("alsu_cmd_driver: LAT must lie in 2..15");
    end
  endgenerate

  state_t      state_r;
  state_t      state_nxt_s;
  logic [3:0]  wait_cnt_r;
  logic [3:0]  wait_cnt_nxt_s;
  cmd_t        req_cmd_s;
  cmd_t        pins_r;
  logic        accept_s;
  logic        capture_s;
  logic        leds_err_s;
  logic        leds_odd_s;
  logic [5:0]  rsp_out_r;
  logic        rsp_err_r;
  logic        mon_fault_r;
  logic [15:0] op_count_r;
  logic [15:0] err_count_r;

  assign req_cmd_s = '{a: bus.req_a, b: bus.req_b, opcode: bus.req_opcode,
                       cin: bus.req_cin, serial_in: bus.req_serial_in,
                       direction: bus.req_direction, red_a: bus.req_red_a,
                       red_b: bus.req_red_b, bypass_a: bus.req_bypass_a,
                       bypass_b: bus.req_bypass_b};

  assign bus.req_ready = (state_r == IDLE) && !rst;
  assign bus.rsp_valid = (state_r == RESP);
  assign accept_s      = bus.req_valid && bus.req_ready;
  assign capture_s     = (state_r == CAPT);
  assign leds_err_s    = (bus.alsu_leds == 16'hFFFF);
  assign leds_odd_s    = (bus.alsu_leds != 16'h0000) && (bus.alsu_leds != 16'hFFFF);

  // State register and WAIT down-counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      wait_cnt_r <= 4'd0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
    end
  end

  // Next-state and WAIT counter logic.
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = DRIVE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DRIVE: begin
        state_nxt_s    = WAIT;
        wait_cnt_nxt_s = WAIT_LOAD;
      end
      WAIT: begin
        if (wait_cnt_r <= 4'd1) begin
          state_nxt_s    = CAPT;
          wait_cnt_nxt_s = 4'd0;
        end else begin
          state_nxt_s    = WAIT;
          wait_cnt_nxt_s = wait_cnt_r - 4'd1;
        end
      end
      CAPT: begin
        state_nxt_s = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: begin
        state_nxt_s    = IDLE;
        wait_cnt_nxt_s = 4'd0;
      end
    endcase
  end

  // Pin register: the command is present only in the cycle after its accept edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pins_r <= IDLE_CMD;
    end else if (accept_s) begin
      pins_r <= req_cmd_s;
    end else begin
      pins_r <= IDLE_CMD;
    end
  end

  assign bus.alsu_a         = pins_r.a;
  assign bus.alsu_b         = pins_r.b;
  assign bus.alsu_opcode    = pins_r.opcode;
  assign bus.alsu_cin       = pins_r.cin;
  assign bus.alsu_serial_in = pins_r.serial_in;
  assign bus.alsu_direction = pins_r.direction;
  assign bus.alsu_red_a     = pins_r.red_a;
  assign bus.alsu_red_b     = pins_r.red_b;
  assign bus.alsu_bypass_a  = pins_r.bypass_a;
  assign bus.alsu_bypass_b  = pins_r.bypass_b;

  // Result capture, sticky leds monitor and wrapping operation counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_out_r   <= 6'd0;
      rsp_err_r   <= 1'b0;
      mon_fault_r <= 1'b0;
      op_count_r  <= 16'd0;
      err_count_r <= 16'd0;
    end else if (capture_s) begin
      rsp_out_r   <= bus.alsu_out;
      rsp_err_r   <= leds_err_s;
      mon_fault_r <= mon_fault_r | leds_odd_s;
      op_count_r  <= op_count_r + 16'd1;
      err_count_r <= leds_err_s ? (err_count_r + 16'd1) : err_count_r;
    end else begin
      rsp_out_r   <= rsp_out_r;
      rsp_err_r   <= rsp_err_r;
      mon_fault_r <= mon_fault_r;
      op_count_r  <= op_count_r;
      err_count_r <= err_count_r;
    end
  end

  assign bus.rsp_out   = rsp_out_r;
  assign bus.rsp_err   = rsp_err_r;
  assign bus.mon_fault = mon_fault_r;
  assign bus.op_count  = op_count_r;
  assign bus.err_count = err_count_r;

endmodule

// File: tb/tb_alsu_cmd_driver.sv
// Bench for alsu_cmd_driver: a cycle-level ALSU stand-in answers the pins, and a
// behavioural reference predicts every response, latency and counter value.
module tb_alsu_cmd_driver;
  localparam int LAT = 2;

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] opcode;
    logic       cin;
    logic       serial_in;
    logic       direction;
    logic       red_a;
    logic       red_b;
    logic       bypass_a;
    logic       bypass_b;
  } cmd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alsu_cmd_driver_if bus ();
  alsu_cmd_driver #(.LAT(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic cmd_t mk(input logic [2:0] a, input logic [2:0] b, input logic [2:0] op,
                              input logic cin, input logic ser, input logic dir,
                              input logic ra, input logic rb, input logic ba, input logic bb);
    cmd_t c;
    c = '{a: a, b: b, opcode: op, cin: cin, serial_in: ser, direction: dir,
          red_a: ra, red_b: rb, bypass_a: ba, bypass_b: bb};
    return c;
  endfunction

  cmd_t idle_pins;
  cmd_t pins_s;
  assign pins_s = {bus.alsu_a, bus.alsu_b, bus.alsu_opcode, bus.alsu_cin, bus.alsu_serial_in,
                   bus.alsu_direction, bus.alsu_red_a, bus.alsu_red_b, bus.alsu_bypass_a,
                   bus.alsu_bypass_b};

  // ---------------- ALSU stand-in: input register, then out/leds register ----------------
  cmd_t        alsu_in_q;
  logic [5:0]  alsu_out_q;
  logic [15:0] alsu_leds_q;
  logic        leds_force = 1'b0;

  function automatic logic [21:0] alsu_step(input cmd_t c, input logic [5:0] po, input logic [15:0] pl);
    logic       bad;
    logic [5:0] o;
    bad = (c.opcode == 3'b110) || (c.opcode == 3'b111) ||
          ((c.red_a || c.red_b) && (c.opcode != 3'b000) && (c.opcode != 3'b001));
    if (bad) return {~pl, 6'd0};
    if (c.bypass_a) o = {3'd0, c.a};
    else if (c.bypass_b) o = {3'd0, c.b};
    else begin
      case (c.opcode)
        3'b000:  o = c.red_a ? {5'd0, &c.a} : (c.red_b ? {5'd0, &c.b} : {3'd0, c.a & c.b});
        3'b001:  o = c.red_a ? {5'd0, ^c.a} : (c.red_b ? {5'd0, ^c.b} : {3'd0, c.a ^ c.b});
        3'b010:  o = 6'(c.a) + 6'(c.b) + 6'(c.cin);
        3'b011:  o = 6'(c.a) * 6'(c.b);
        3'b100:  o = c.direction ? {po[4:0], c.serial_in} : {c.serial_in, po[5:1]};
        default: o = c.direction ? {po[4:0], po[5]} : {po[0], po[5:1]};
      endcase
    end
    return {16'h0000, o};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      alsu_in_q   <= '0;
      alsu_out_q  <= 6'd0;
      alsu_leds_q <= 16'h0000;
    end else begin
      alsu_in_q <= pins_s;
      {alsu_leds_q, alsu_out_q} <= alsu_step(alsu_in_q, alsu_out_q, alsu_leds_q);
    end
  end

  assign bus.alsu_out  = alsu_out_q;
  assign bus.alsu_leds = leds_force ? 16'h00F0 : alsu_leds_q;

  // ---------------- reference model (command result seen after an idle gap) ----------------
  int   exp_ops  = 0;
  int   exp_errs = 0;
  logic exp_mon  = 1'b0;

  task automatic expect_result(input cmd_t c, output logic [5:0] out, output logic err);
    int a, b;
    a = int'(c.a);
    b = int'(c.b);
    err = (c.opcode > 3'd5) || ((c.red_a || c.red_b) && c.opcode > 3'd1);
    out = 6'd0;
    if (err) out = 6'd0;
    else if (c.bypass_a) out = 6'(a);
    else if (c.bypass_b) out = 6'(b);
    else if (c.opcode == 3'd0 && c.red_a) out = (a == 7) ? 6'd1 : 6'd0;
    else if (c.opcode == 3'd0 && c.red_b) out = (b == 7) ? 6'd1 : 6'd0;
    else if (c.opcode == 3'd0) out = 6'(a & b);
    else if (c.opcode == 3'd1 && c.red_a) out = 6'($countones(c.a) % 2);
    else if (c.opcode == 3'd1 && c.red_b) out = 6'($countones(c.b) % 2);
    else if (c.opcode == 3'd1) out = 6'(a ^ b);
    else if (c.opcode == 3'd2) out = 6'((a + b + int'(c.cin)) % 64);
    else if (c.opcode == 3'd3) out = 6'(a * b);
    else if (c.opcode == 3'd4) out = !c.serial_in ? 6'd0 : (c.direction ? 6'd1 : 6'd32);
    else out = 6'd0;  // rotating the parked zero result
  endtask

  task automatic set_req(input cmd_t c);
    bus.req_a = c.a;   bus.req_b = c.b;   bus.req_opcode = c.opcode;
    bus.req_cin = c.cin;   bus.req_serial_in = c.serial_in;   bus.req_direction = c.direction;
    bus.req_red_a = c.red_a;   bus.req_red_b = c.red_b;
    bus.req_bypass_a = c.bypass_a;   bus.req_bypass_b = c.bypass_b;
  endtask

  task automatic run_op(input cmd_t c, input int hold, input bit keep_valid, input bit fault);
    int         cyc;
    bit         seen;
    logic [5:0] e_out;
    logic       e_err;
    @(negedge clk);
    check_eq("req_ready_idle", bus.req_ready, 1);
    set_req(c);
    bus.req_valid = 1'b1;
    leds_force = fault;
    @(posedge clk);
    @(negedge clk);
    if (!keep_valid) bus.req_valid = 1'b0;
    check_eq("pins_cmd", pins_s, c);
    cyc = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (bus.rsp_valid) seen = 1'b1;
      else begin
        check_eq("pins_idle", pins_s, idle_pins);
        check_eq("req_ready_busy", bus.req_ready, 0);
      end
    end
    bus.req_valid = 1'b0;
    leds_force = 1'b0;
    check_eq("rsp_seen", seen, 1);
    check_eq("latency", cyc, LAT + 1);
    expect_result(c, e_out, e_err);
    if (fault) e_err = 1'b0;
    exp_mon  = exp_mon | fault;
    exp_ops  = exp_ops + 1;
    exp_errs = exp_errs + int'(e_err);
    check_eq("rsp_out", bus.rsp_out, e_out);
    check_eq("rsp_err", bus.rsp_err, e_err);
    check_eq("mon_fault", bus.mon_fault, exp_mon);
    check_eq("op_count", bus.op_count, exp_ops % 65536);
    check_eq("err_count", bus.err_count, exp_errs % 65536);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("hold_valid", bus.rsp_valid, 1);
      check_eq("hold_out", bus.rsp_out, e_out);
      check_eq("hold_ready", bus.req_ready, 0);
      check_eq("hold_pins", pins_s, idle_pins);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check_eq("post_valid", bus.rsp_valid, 0);
    check_eq("post_ready", bus.req_ready, 1);
  endtask

  initial begin
    int spurious;
    idle_pins = mk(3'd0, 3'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    set_req(idle_pins);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_req_ready", bus.req_ready, 1);
    check_eq("rst_rsp_valid", bus.rsp_valid, 0);
    check_eq("rst_pins", pins_s, idle_pins);
    check_eq("rst_rsp_out", bus.rsp_out, 0);
    check_eq("rst_counts", {bus.op_count, bus.err_count}, 0);

    run_op(mk(3'd3, 3'd5, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 0, 1'b0, 1'b0);
    run_op(mk(3'd3, 3'd5, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 0, 1'b0, 1'b0);
    run_op(mk(3'd3, 3'd5, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 0, 1'b0, 1'b0);
    run_op(mk(3'd7, 3'd1, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 0, 1'b0, 1'b0);
    run_op(mk(3'd2, 3'd4, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 0, 1'b0, 1'b0);
    run_op(mk(3'd3, 3'd6, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1), 5, 1'b1, 1'b0);
    run_op(mk(3'd5, 3'd3, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 0, 1'b0, 1'b1);
    run_op(mk(3'd4, 3'd4, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1, 1'b0, 1'b0);
    run_op(mk(3'd0, 3'd0, 3'b100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 0, 1'b0, 1'b0);

    // Reset while the command is in WAIT: nothing may come back and counts clear.
    @(negedge clk);
    set_req(mk(3'd6, 3'd6, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst_valid", bus.rsp_valid, 0);
    check_eq("mid_rst_pins", pins_s, idle_pins);
    check_eq("mid_rst_rsp", {bus.rsp_out, bus.rsp_err}, 0);
    check_eq("mid_rst_mon", bus.mon_fault, 0);
    check_eq("mid_rst_counts", {bus.op_count, bus.err_count}, 0);
    exp_ops = 0;
    exp_errs = 0;
    exp_mon = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    spurious = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.rsp_valid) spurious++;
    end
    check_eq("no_rsp_after_rst", spurious, 0);
    check_eq("count_after_rst", bus.op_count, 0);

    for (int n = 0; n < 40; n++) begin
      cmd_t c;
      c = cmd_t'($urandom_range(0, 65535));
      run_op(c, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end
endmodule
